// File: rtl/mul_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 4x4 unsigned multiplier.
// Each operation walks IDLE -> CALC (MUL_LAT cycles) -> DONE; every output is registered.
module mul_arbiter #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq0,
    input  logic [3:0] iA0,
    input  logic [3:0] iB0,
    input  logic       iReq1,
    input  logic [3:0] iA1,
    input  logic [3:0] iB1,
    output logic       oGnt0,
    output logic       oGnt1,
    output logic       oValid,
    output logic [7:0] oResult,
    output logic       oId,
    output logic       oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       id_q, id_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       valid_q, valid_d;
    logic [7:0] result_q, result_d;
    logic       out_id_q, out_id_d;
    logic       busy_q, busy_d;
    logic       win;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        valid_d  = 1'b0;
        result_d = result_q;
        out_id_d = out_id_q;

        // Contention goes to the pointer; otherwise the sole requester wins.
        win = (iReq0 && iReq1) ? ptr_q : iReq1;

        case (state_q)
            IDLE: begin
                if (iReq0 || iReq1) begin
                    state_d = CALC;
                    id_d    = win;
                    a_d     = win ? iA1 : iA0;
                    b_d     = win ? iB1 : iB0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    cnt_d   = CNT_LOAD;
                    ptr_d   = ~win;
                end
            end
            CALC: begin
                if (cnt_q == 4'd0) begin
                    state_d  = DONE;
                    result_d = {4'd0, a_q} * {4'd0, b_q};
                    out_id_d = id_q;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!Reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= 4'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            id_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= 8'd0;
            out_id_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            out_id_q <= out_id_d;
            busy_q   <= busy_d;
        end
    end

    assign oGnt0   = gnt0_q;
    assign oGnt1   = gnt1_q;
    assign oValid  = valid_q;
    assign oResult = result_q;
    assign oId     = out_id_q;
    assign oBusy   = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed vectors push expected {id, product},
// per-instance monitors pop and compare on every oValid pulse.
module tb_mul_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, valid, id, busy;
    logic [7:0] result;

    logic       t_req0, t_req1;
    logic       t_gnt0, t_gnt1, t_valid, t_id, t_busy;
    logic [7:0] t_result;

    int n_vec = 0;
    int n_err = 0;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    mul_arbiter #(.MUL_LAT(1)) dut (
        .Clock(clk), .Reset(rst_n),
        .iReq0(req0), .iA0(a0), .iB0(b0),
        .iReq1(req1), .iA1(a1), .iB1(b1),
        .oGnt0(gnt0), .oGnt1(gnt1), .oValid(valid),
        .oResult(result), .oId(id), .oBusy(busy)
    );

    mul_arbiter #(.MUL_LAT(3)) dut3 (
        .Clock(clk), .Reset(rst_n),
        .iReq0(t_req0), .iA0(a0), .iB0(b0),
        .iReq1(t_req1), .iA1(a1), .iB1(b1),
        .oGnt0(t_gnt0), .oGnt1(t_gnt1), .oValid(t_valid),
        .oResult(t_result), .oId(t_id), .oBusy(t_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor for the MUL_LAT=1 instance.
    always @(negedge clk) begin
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
            check("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
            check("valid_during_gnt", {31'd0, valid}, 32'd0);
        end
        if (valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("valid_id", {31'd0, id}, {31'd0, e1.id});
                check("valid_result", {24'd0, result}, {24'd0, e1.res});
            end
        end
    end

    // Monitor for the MUL_LAT=3 instance.
    always @(negedge clk) begin
        if (t_valid === 1'b1) begin
            if (q3.size() == 0) begin
                check("lat3_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                check("lat3_valid_id", {31'd0, t_id}, {31'd0, e3.id});
                check("lat3_valid_result", {24'd0, t_result}, {24'd0, e3.res});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants, valids, last_v, busy_cnt, lat;

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; t_req0 = 1'b0; t_req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        repeat (2) step();
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_valid_busy", {30'd0, valid, busy}, 32'd0);
        check("rst_result_id", {23'd0, id, result}, 32'd0);
        check("rst3_outputs", {21'd0, t_gnt0, t_gnt1, t_valid, t_busy, t_id, t_result}, 32'd0);

        // Single request, 15*15.
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
        q1.push_back(exp_t'{1'b0, 8'd225});
        step();
        check("t1_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        check("t1_busy_calc", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        step();
        check("t1_valid", {30'd0, valid, gnt0}, 32'd2);
        check("t1_busy_done", {31'd0, busy}, 32'd1);
        step();
        check("t1_idle", {30'd0, busy, valid}, 32'd0);

        // Simultaneous requests straight after reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd4;
        req1 = 1'b1; a1 = 4'd7; b1 = 4'd9;
        q1.push_back(exp_t'{1'b0, 8'd12});
        q1.push_back(exp_t'{1'b1, 8'd63});
        step();
        check("t2_first_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        step();
        step();
        check("t2_gap_no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        step();
        check("t2_second_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        repeat (2) step();

        // Continuous contention for four operations.
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd5;
        req1 = 1'b1; a1 = 4'd6; b1 = 4'd7;
        q1.push_back(exp_t'{1'b0, 8'd10});
        q1.push_back(exp_t'{1'b1, 8'd42});
        q1.push_back(exp_t'{1'b0, 8'd10});
        q1.push_back(exp_t'{1'b1, 8'd42});
        grants = 0; valids = 0; last_v = -1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                grants++;
                if (grants == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (valid === 1'b1) begin
                if (valids > 0) check("t3_valid_spacing", c - last_v, 32'd3);
                last_v = c;
                valids++;
            end
        end
        check("t3_valid_count", valids, 32'd4);

        // Zero operand, late operand change, request raised during CALC.
        req1 = 1'b1; a1 = 4'd0; b1 = 4'd9;
        q1.push_back(exp_t'{1'b1, 8'd0});
        step();
        check("t4_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        a1 = 4'd5; req1 = 1'b0;
        req0 = 1'b1; a0 = 4'd4; b0 = 4'd4;
        q1.push_back(exp_t'{1'b0, 8'd16});
        step();
        check("t4_done_no_gnt", {30'd0, valid, gnt0}, 32'd2);
        step();
        check("t4_idle_no_gnt", {30'd0, busy, gnt0}, 32'd0);
        step();
        check("t4_late_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        repeat (2) step();

        // Reset in the CALC cycle aborts the operation.
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
        step();
        check("t5_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        rst_n = 1'b0; req0 = 1'b0;
        step();
        check("t5_abort_valid_busy", {30'd0, valid, busy}, 32'd0);
        check("t5_abort_result", {23'd0, id, result}, 32'd0);
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd2;
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd3;
        q1.push_back(exp_t'{1'b0, 8'd2});
        q1.push_back(exp_t'{1'b1, 8'd9});
        step();
        check("t5_post_reset_winner", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        repeat (3) step();
        check("t5_second_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        repeat (3) step();

        // MUL_LAT=3 instance: latency and busy width.
        t_req1 = 1'b1; a1 = 4'd10; b1 = 4'd12;
        q3.push_back(exp_t'{1'b1, 8'd120});
        step();
        check("t6_gnt1", {30'd0, t_gnt1, t_gnt0}, 32'd2);
        t_req1 = 1'b0; a1 = 4'd1;
        busy_cnt = (t_busy === 1'b1) ? 1 : 0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (t_busy === 1'b1) busy_cnt++;
            if (t_valid === 1'b1) lat = c;
        end
        check("t6_latency", lat, 32'd3);
        check("t6_busy_cycles", busy_cnt, 32'd4);

        check("q1_drained", q1.size(), 32'd0);
        check("q3_drained", q3.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
